commit_monitor: RTL and testbench

Parametrised, synthesizable commit monitor for the RV32I pipeline and its multi-issue successors. It accepts up to `NRET` retirements per cycle and assigns each a monotonic order number. It detects the branch-to-self halt idiom after a configurable number of repeats and flags commit starvation with a watchdog. It also flags non-contiguous lane usage. It sits beside the writeback/commit stage and drives the RVFI order/halt signals and bench termination.

---
 rtl/commit_mon_pkg.sv | 14 +
 rtl/commit_prefix_count.sv | 33 +++
 rtl/commit_monitor.sv | 140 ++++++++++++++
 tb/tb_commit_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_mon_pkg.sv
// Shared types and constants for the commit monitor: FSM state encoding
// and the width of the self-loop repeat counter.
package commit_mon_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALTED    = 2'd1,
        TIMED_OUT = 2'd2
    } cm_state_t;

    // Wide enough for the largest supported HALT_REPEAT (255).
    localparam int LOOP_CNT_W = 8;

endpackage

// File: rtl/commit_prefix_count.sv
// Exclusive prefix popcounts and total popcount of an NRET-bit vector.
// prefix slice i holds the number of set bits in vec[i-1:0].
module commit_prefix_count #(
    parameter int NRET = 2,
    localparam int CW  = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]    vec,
    output logic [NRET*CW-1:0] prefix,
    output logic [CW-1:0]      total
);

    genvar gi;
    generate
        for (gi = 0; gi < NRET; gi++) begin : g_pre
            logic [CW-1:0] acc;
            always_comb begin
                acc = '0;
                for (int j = 0; j < gi; j++) begin
                    acc = acc + CW'(vec[j]);
                end
            end
            assign prefix[gi*CW +: CW] = acc;
        end
    endgenerate

    always_comb begin
        total = '0;
        for (int j = 0; j < NRET; j++) begin
            total = total + CW'(vec[j]);
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Multi-lane commit monitor: assigns order numbers to retiring lanes,
// detects the branch-to-self halt idiom, commit starvation and lane gaps.
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int NRET           = 2,
    parameter int XLEN           = 32,
    parameter int ORDER_W        = 64,
    parameter int HALT_REPEAT    = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRET-1:0]         commit_valid,
    input  logic [NRET*XLEN-1:0]    commit_pc,
    input  logic [NRET*XLEN-1:0]    commit_pc_next,
    input  logic [NRET-1:0]         commit_ctrl,
    input  logic                    clear,
    output logic [NRET*ORDER_W-1:0] order,
    output logic [NRET-1:0]         counted,
    output logic                    halt,
    output logic                    timeout,
    output logic                    lane_error,
    output logic [ORDER_W-1:0]      commit_total
);

    localparam int CW     = $clog2(NRET + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX =
        (TIMEOUT_CYCLES > 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [LOOP_CNT_W-1:0] HALT_LIM = LOOP_CNT_W'(HALT_REPEAT);

    cm_state_t              state_reg;
    logic [LOOP_CNT_W-1:0]  loop_cnt_reg, loop_cnt_next;
    logic [IDLE_W-1:0]      idle_cnt_reg;
    logic [ORDER_W-1:0]     total_reg;
    logic                   halt_reg, timeout_reg, lane_error_reg;
    logic                   halt_hit;
    logic [NRET-1:0]        self_loop, lane_gap, counted_int;
    logic [NRET*CW-1:0]     prefix_flat;
    logic [CW-1:0]          count_total;
    logic                   any_valid;

    assign any_valid = |commit_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NRET; gi++) begin : g_lane
            assign self_loop[gi] = commit_valid[gi] & commit_ctrl[gi] &
                (commit_pc_next[gi*XLEN +: XLEN] == commit_pc[gi*XLEN +: XLEN]);
            if (gi == 0) begin : g_first
                assign lane_gap[gi] = 1'b0;
            end else begin : g_rest
                assign lane_gap[gi] = commit_valid[gi] & ~commit_valid[gi-1];
            end
            assign order[gi*ORDER_W +: ORDER_W] =
                total_reg + ORDER_W'(prefix_flat[gi*CW +: CW]);
        end
    endgenerate

    // Walk lanes in ascending order; everything above the halting lane is dropped.
    always_comb begin
        loop_cnt_next = loop_cnt_reg;
        halt_hit      = 1'b0;
        counted_int   = '0;
        for (int i = 0; i < NRET; i++) begin
            if (commit_valid[i] && (state_reg == RUN) && !halt_hit) begin
                counted_int[i] = 1'b1;
                if (self_loop[i]) begin
                    if (loop_cnt_next != HALT_LIM)
                        loop_cnt_next = loop_cnt_next + LOOP_CNT_W'(1);
                end else begin
                    loop_cnt_next = '0;
                end
                if (loop_cnt_next == HALT_LIM)
                    halt_hit = 1'b1;
            end
        end
    end

    commit_prefix_count #(
        .NRET (NRET)
    ) u_prefix (
        .vec    (counted_int),
        .prefix (prefix_flat),
        .total  (count_total)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            loop_cnt_reg   <= '0;
            idle_cnt_reg   <= '0;
            total_reg      <= '0;
            halt_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            lane_error_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    total_reg      <= total_reg + ORDER_W'(count_total);
                    lane_error_reg <= lane_error_reg | (|lane_gap);
                    loop_cnt_reg   <= loop_cnt_next;
                    if (any_valid)
                        idle_cnt_reg <= '0;
                    else if (TIMEOUT_EN && idle_cnt_reg != IDLE_MAX)
                        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                    if (halt_hit) begin
                        state_reg <= HALTED;
                        halt_reg  <= 1'b1;
                    end else if (TIMEOUT_EN && !any_valid && idle_cnt_reg == IDLE_MAX) begin
                        state_reg   <= TIMED_OUT;
                        timeout_reg <= 1'b1;
                    end
                    if (clear) begin
                        loop_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                    end
                end
                default: begin
                    if (clear) begin
                        state_reg    <= RUN;
                        halt_reg     <= 1'b0;
                        timeout_reg  <= 1'b0;
                        loop_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign counted      = counted_int;
    assign halt         = halt_reg;
    assign timeout      = timeout_reg;
    assign lane_error   = lane_error_reg;
    assign commit_total = total_reg;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: dut_a (HALT_REPEAT=2) and dut_b
// (HALT_REPEAT=1) share stimulus, both with an 8-cycle watchdog.
module tb_commit_monitor;

    localparam int NRET = 2;
    localparam int XLEN = 32;
    localparam int OW   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NRET-1:0]      commit_valid;
    logic [NRET*XLEN-1:0] commit_pc;
    logic [NRET*XLEN-1:0] commit_pc_next;
    logic [NRET-1:0]      commit_ctrl;
    logic                 clear;

    logic [NRET*OW-1:0]   a_order, b_order;
    logic [NRET-1:0]      a_counted, b_counted;
    logic                 a_halt, b_halt, a_timeout, b_timeout;
    logic                 a_lane_error, b_lane_error;
    logic [OW-1:0]        a_total, b_total;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_monitor #(
        .NRET(NRET), .XLEN(XLEN), .ORDER_W(OW), .HALT_REPEAT(2), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_pc_next(commit_pc_next), .commit_ctrl(commit_ctrl), .clear(clear),
        .order(a_order), .counted(a_counted), .halt(a_halt), .timeout(a_timeout),
        .lane_error(a_lane_error), .commit_total(a_total)
    );

    commit_monitor #(
        .NRET(NRET), .XLEN(XLEN), .ORDER_W(OW), .HALT_REPEAT(1), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_pc_next(commit_pc_next), .commit_ctrl(commit_ctrl), .clear(clear),
        .order(b_order), .counted(b_counted), .halt(b_halt), .timeout(b_timeout),
        .lane_error(b_lane_error), .commit_total(b_total)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic [31:0] nxt, input logic ctrl);
        commit_valid[i]            = v;
        commit_pc[i*XLEN +: XLEN]      = pc;
        commit_pc_next[i*XLEN +: XLEN] = nxt;
        commit_ctrl[i]             = ctrl;
    endtask

    task automatic go_idle();
        commit_valid = '0;
        commit_ctrl  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        go_idle();
        clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        clear          = 1'b0;
        commit_valid   = '0;
        commit_ctrl    = '0;
        commit_pc      = '0;
        commit_pc_next = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_halt", 64'(a_halt), 64'd0);
        check_eq("rst_timeout", 64'(a_timeout), 64'd0);
        check_eq("rst_lane_error", 64'(a_lane_error), 64'd0);
        check_eq("rst_total", a_total, 64'd0);
        rst_n = 1'b1;
        step();

        // Dual-lane ordering
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 1'b1, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k), 1'b0);
            set_lane(1, 1'b1, 32'h104 + 32'(8*k), 32'h108 + 32'(8*k), 1'b0);
            settle();
            check_eq($sformatf("dual_counted_%0d", k), 64'(a_counted), 64'd3);
            check_eq($sformatf("dual_order0_%0d", k), a_order[0 +: OW], 64'(2*k));
            check_eq($sformatf("dual_order1_%0d", k), a_order[OW +: OW], 64'(2*k + 1));
            step();
        end
        go_idle();
        settle();
        check_eq("dual_total", a_total, 64'd6);

        // Halt after two self-loop repeats
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_lane(0, 1'b1, 32'h60, 32'h60, 1'b1);
            set_lane(1, 1'b0, 32'h0, 32'h0, 1'b0);
            settle();
            check_eq($sformatf("rep_counted_%0d", k), 64'(a_counted), 64'd1);
            check_eq($sformatf("rep_order0_%0d", k), a_order[0 +: OW], 64'(k));
            check_eq($sformatf("rep_halt_pre_%0d", k), 64'(a_halt), 64'd0);
            step();
        end
        set_lane(0, 1'b1, 32'h300, 32'h304, 1'b0);
        set_lane(1, 1'b1, 32'h304, 32'h308, 1'b0);
        settle();
        check_eq("rep_halt", 64'(a_halt), 64'd1);
        check_eq("rep_counted_halted", 64'(a_counted), 64'd0);
        step();
        go_idle();
        settle();
        check_eq("rep_total_frozen", a_total, 64'd2);

        // Intra-cycle halt: self-loop on upper lane
        do_reset();
        set_lane(0, 1'b1, 32'h200, 32'h204, 1'b0);
        set_lane(1, 1'b1, 32'h80, 32'h80, 1'b1);
        settle();
        check_eq("intra_hi_counted", 64'(b_counted), 64'd3);
        check_eq("intra_hi_order1", b_order[OW +: OW], 64'd1);
        check_eq("intra_hi_halt_pre", 64'(b_halt), 64'd0);
        step();
        go_idle();
        settle();
        check_eq("intra_hi_halt", 64'(b_halt), 64'd1);
        check_eq("intra_hi_total", b_total, 64'd2);

        // Intra-cycle halt: self-loop on lane 0 blocks lane 1
        do_reset();
        set_lane(0, 1'b1, 32'h80, 32'h80, 1'b1);
        set_lane(1, 1'b1, 32'h84, 32'h88, 1'b0);
        settle();
        check_eq("intra_lo_counted", 64'(b_counted), 64'd1);
        check_eq("intra_lo_a_counted", 64'(a_counted), 64'd3);
        step();
        go_idle();
        settle();
        check_eq("intra_lo_halt", 64'(b_halt), 64'd1);
        check_eq("intra_lo_total", b_total, 64'd1);

        // Watchdog
        do_reset();
        set_lane(0, 1'b1, 32'h400, 32'h404, 1'b0);
        set_lane(1, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check_eq("wd_counted", 64'(a_counted), 64'd1);
        step();
        go_idle();
        for (int k = 1; k < 8; k++) step();
        settle();
        check_eq("wd_timeout_cycle8", 64'(a_timeout), 64'd0);
        step();
        settle();
        check_eq("wd_timeout", 64'(a_timeout), 64'd1);
        set_lane(0, 1'b1, 32'h500, 32'h504, 1'b0);
        set_lane(1, 1'b1, 32'h504, 32'h508, 1'b0);
        settle();
        check_eq("wd_counted_timed_out", 64'(a_counted), 64'd0);
        step();
        go_idle();
        clear = 1'b1;
        settle();
        step();
        clear = 1'b0;
        set_lane(0, 1'b1, 32'h600, 32'h604, 1'b0);
        settle();
        check_eq("wd_cleared", 64'(a_timeout), 64'd0);
        check_eq("wd_order_resume", a_order[0 +: OW], 64'd1);
        check_eq("wd_counted_resume", 64'(a_counted), 64'd1);
        step();
        go_idle();
        settle();
        check_eq("wd_total", a_total, 64'd2);

        // Lane error
        set_lane(0, 1'b1, 32'h700, 32'h704, 1'b0);
        set_lane(1, 1'b1, 32'h704, 32'h708, 1'b0);
        step();
        set_lane(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_lane(1, 1'b1, 32'h710, 32'h714, 1'b0);
        settle();
        check_eq("gap_counted", 64'(a_counted), 64'd2);
        check_eq("gap_order1", a_order[OW +: OW], 64'd4);
        check_eq("gap_lane_error_pre", 64'(a_lane_error), 64'd0);
        step();
        go_idle();
        settle();
        check_eq("gap_lane_error", 64'(a_lane_error), 64'd1);
        check_eq("gap_total", a_total, 64'd5);

        // Asynchronous reset between edges
        set_lane(0, 1'b1, 32'h800, 32'h804, 1'b0);
        set_lane(1, 1'b1, 32'h804, 32'h808, 1'b0);
        settle();
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_total", a_total, 64'd0);
        check_eq("arst_lane_error", 64'(a_lane_error), 64'd0);
        check_eq("arst_b_halt", 64'(b_halt), 64'd0);
        #1 rst_n = 1'b1;
        #1;
        check_eq("arst_order0", a_order[0 +: OW], 64'd0);
        check_eq("arst_order1", a_order[OW +: OW], 64'd1);
        step();
        go_idle();
        settle();
        check_eq("arst_total_after", a_total, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
